calc_seq_ctrl: RTL
==================

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits per operand; W = 4*DIGITS.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for alu_done.
REQ-003 SHALL have these ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low.
- key_valid  input  1  level; high while a key is pressed.
- key_code  input  4  key: 0-9 digit, 10 '=', 11 AC, 12 +, 13 -, 14 *, 15 /.
- alu_res  input  W  ALU result.
- alu_done  input  1  one-cycle ALU completion strobe.
- alu_err  input  1  qualifies alu_done; high means ALU fault (e.g. divide by zero).
- operand_a  output  W  first operand.
- operand_b  output  W  second operand.
- op  output  4  pending operation code (12-15).
- alu_start  output  1  one-cycle request to the ALU.
- display  output  W  value to show.
- err_flag  output  1  high while in ERROR.

Function
REQ-004 A key SHALL be accepted only on the cycle where key_valid is 1 and was 0 on the previous cycle; key_code SHALL be sampled in that same cycle; one press SHALL yield exactly one accepted key.
REQ-005 The FSM SHALL have states ENTER_A, ENTER_B, CALC, SHOW and ERROR.
REQ-006 A digit entry SHALL shift the operand left one nibble and insert the digit in bits [3:0]; when the top nibble is nonzero the digit SHALL be ignored (no wrap).
REQ-007 In ENTER_A:
- digit -> shift into A.
- operator -> op = key; B = 0; go to ENTER_B.
- AC -> A = 0.
- '=' -> ignored.
REQ-008 In ENTER_B:
- digit -> shift into B; set b_entered.
- AC with B != 0 -> B = 0.
- AC with B == 0 -> A = 0; op = 12; go to ENTER_A.
- '=' -> go to CALC; chain = 0.
- operator with b_entered = 0 -> replace op.
- operator with b_entered = 1 -> pending_op = key; chain = 1; go to CALC.
REQ-009 alu_start SHALL be high for exactly the first cycle in CALC; otherwise 0.
REQ-010 In CALC, digit, operator and '=' keys SHALL be ignored.
REQ-011 In CALC on alu_done:
- alu_err = 1 -> go to ERROR.
- alu_err = 0 and chain = 1 -> A = alu_res; B = 0; op = pending_op; clear b_entered; go to ENTER_B.
- alu_err = 0 and chain = 0 -> result = alu_res; go to SHOW.
REQ-012 CALC SHALL count cycles; if TIMEOUT cycles elapse without alu_done, the FSM SHALL go to ERROR.
REQ-013 AC accepted in CALC SHALL abort: clear A, B, result; op = 12; go to ENTER_A. If AC and alu_done occur in the same cycle, AC wins and alu_done is dropped.
REQ-014 In SHOW:
- digit -> A = digit; B = 0; go to ENTER_A.
- operator -> A = result; op = key; B = 0; go to ENTER_B.
- '=' -> A = result, B unchanged; go to CALC (repeat last operation).
- AC -> full clear; go to ENTER_A.
REQ-015 In ERROR, only AC SHALL be accepted (full clear; go to ENTER_A); every other key and alu_done SHALL be ignored.
REQ-016 display SHALL be combinational from state and registers:
- ENTER_A -> A.
- ENTER_B -> B.
- CALC -> B.
- SHOW -> result.
- ERROR -> every nibble 4'hE.
REQ-017 err_flag SHALL equal (state == ERROR); operand_a, operand_b and op SHALL be held stable throughout CALC.

Reset
REQ-018 While reset = 0, the FSM SHALL be asynchronously forced to:
- state = ENTER_A.
- A, B, result, timeout counter = 0.
- op = pending_op = 12.
- chain = 0, b_entered = 0.
- alu_start = 0, err_flag = 0.
REQ-019 The key-edge history register SHALL reset to 1, so a key held through reset release is not accepted until it is released and pressed again.
REQ-020 Reset asserted mid-CALC SHALL cancel the operation; an alu_done arriving after release SHALL be ignored.

Verification
REQ-021 Keys 1,2,+,3,= with alu_res = 0x0015 and alu_done 3 cycles after alu_start -> operand_a = 0x0012, operand_b = 0x0003, op = 12, one alu_start pulse, display = 0x0015 in SHOW.
REQ-022 DIGITS = 4, keys 1,2,3,4,5 -> A = 0x1234, fifth digit ignored.
REQ-023 Chaining: keys 9,+,1,- (alu_res = 0x0010), then 2,= (alu_res = 0x0008) -> after the first done, state = ENTER_B, A = 0x0010, op = 13; final display = 0x0008.
REQ-024 Keys 5,/,0,= with alu_done and alu_err = 1 -> state = ERROR, display = 0xEEEE, err_flag = 1; digit keys ignored; AC -> ENTER_A, A = 0.
REQ-025 TIMEOUT = 8, alu_done never asserted -> ERROR exactly 8 cycles after CALC entry. Separately, AC coinciding with alu_done -> ENTER_A with A = B = 0.
REQ-026 key_valid held high for 20 cycles -> exactly one accepted key. key_valid high across reset release -> no key accepted until key_valid falls and rises again.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for a BCD calculator: collects operands from a keypad,
// hands operations to an external ALU, handles chaining, errors and timeouts.
module calc_seq_ctrl #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic [4*DIGITS-1:0] alu_res,
  input  logic                alu_done,
  input  logic                alu_err,
  output logic [4*DIGITS-1:0] operand_a,
  output logic [4*DIGITS-1:0] operand_b,
  output logic [3:0]          op,
  output logic                alu_start,
  output logic [4*DIGITS-1:0] display,
  output logic                err_flag
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  localparam logic [3:0] KeyEq  = 4'd10;
  localparam logic [3:0] KeyAc  = 4'd11;
  localparam logic [3:0] OpAdd  = 4'd12;

  typedef enum logic [2:0] {StEnterA, StEnterB, StCalc, StShow, StError} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]    op_q, op_d, pending_q, pending_d;
  logic          chain_q, chain_d, b_entered_q, b_entered_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          alu_start_q, alu_start_d;
  logic          key_prev_q;

  logic key_acc, is_digit, is_op, go_calc, full_clear;

  // Rising edge of key_valid; history resets high so a held key is not taken.
  assign key_acc  = key_valid & ~key_prev_q;
  assign is_digit = key_code < 4'd10;
  assign is_op    = key_code >= OpAdd;

  // Shift a digit in from the right unless the operand is already full.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
    logic [W-1:0] r;
    r = v;
    if (v[W-1:W-4] == 4'h0) r = {v[W-5:0], d};
    return r;
  endfunction

  // Next-state and datapath updates for every state.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    op_d        = op_q;
    pending_d   = pending_q;
    chain_d     = chain_q;
    b_entered_d = b_entered_q;
    cnt_d       = cnt_q;
    alu_start_d = 1'b0;
    go_calc     = 1'b0;
    full_clear  = 1'b0;

    unique case (state_q)
      StEnterA: begin
        if (key_acc) begin
          if (is_digit) begin
            a_d = shift_in(a_q, key_code);
          end else if (is_op) begin
            op_d        = key_code;
            b_d         = '0;
            b_entered_d = 1'b0;
            state_d     = StEnterB;
          end else if (key_code == KeyAc) begin
            a_d = '0;
          end
        end
      end
      StEnterB: begin
        if (key_acc) begin
          if (is_digit) begin
            b_d         = shift_in(b_q, key_code);
            b_entered_d = 1'b1;
          end else if (key_code == KeyAc) begin
            if (b_q != '0) begin
              b_d = '0;
            end else begin
              a_d         = '0;
              op_d        = OpAdd;
              b_entered_d = 1'b0;
              state_d     = StEnterA;
            end
          end else if (key_code == KeyEq) begin
            chain_d = 1'b0;
            go_calc = 1'b1;
          end else if (!b_entered_q) begin
            op_d = key_code;
          end else begin
            pending_d = key_code;
            chain_d   = 1'b1;
            go_calc   = 1'b1;
          end
        end
      end
      StCalc: begin
        // Priority: abort, then completion, then timeout.
        if (key_acc && key_code == KeyAc) begin
          full_clear = 1'b1;
        end else if (alu_done) begin
          if (alu_err) begin
            state_d = StError;
          end else if (chain_q) begin
            a_d         = alu_res;
            b_d         = '0;
            op_d        = pending_q;
            b_entered_d = 1'b0;
            state_d     = StEnterB;
          end else begin
            result_d = alu_res;
            state_d  = StShow;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShow: begin
        if (key_acc) begin
          if (is_digit) begin
            a_d     = W'(key_code);
            b_d     = '0;
            state_d = StEnterA;
          end else if (is_op) begin
            a_d         = result_q;
            op_d        = key_code;
            b_d         = '0;
            b_entered_d = 1'b0;
            state_d     = StEnterB;
          end else if (key_code == KeyEq) begin
            a_d     = result_q;
            chain_d = 1'b0;
            go_calc = 1'b1;
          end else begin
            full_clear = 1'b1;
          end
        end
      end
      StError: begin
        if (key_acc && key_code == KeyAc) full_clear = 1'b1;
      end
      default: state_d = StEnterA;
    endcase

    if (go_calc) begin
      state_d     = StCalc;
      cnt_d       = '0;
      alu_start_d = 1'b1;
    end

    if (full_clear) begin
      state_d     = StEnterA;
      a_d         = '0;
      b_d         = '0;
      result_d    = '0;
      op_d        = OpAdd;
      pending_d   = OpAdd;
      chain_d     = 1'b0;
      b_entered_d = 1'b0;
      cnt_d       = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StEnterA;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      op_q        <= OpAdd;
      pending_q   <= OpAdd;
      chain_q     <= 1'b0;
      b_entered_q <= 1'b0;
      cnt_q       <= '0;
      alu_start_q <= 1'b0;
      key_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      op_q        <= op_d;
      pending_q   <= pending_d;
      chain_q     <= chain_d;
      b_entered_q <= b_entered_d;
      cnt_q       <= cnt_d;
      alu_start_q <= alu_start_d;
      key_prev_q  <= key_valid;
    end
  end

  // Display selection from current state.
  always_comb begin
    display = a_q;
    unique case (state_q)
      StEnterA:        display = a_q;
      StEnterB, StCalc: display = b_q;
      StShow:          display = result_q;
      StError:         display = {DIGITS{4'hE}};
      default:         display = a_q;
    endcase
  end

  assign operand_a = a_q;
  assign operand_b = b_q;
  assign op        = op_q;
  assign alu_start = alu_start_q;
  assign err_flag  = (state_q == StError);

endmodule
